// File: rtl/uart_rx_config_set.sv
// UART 8N1 receiver plus config-frame parser for the motor config bus.
// A frame is HDR_BYTE, BUS_BYTES payload bytes (MSB byte first) and an XOR
// checksum over the payload. Only a complete, checksum-clean frame replaces
// busNow; anything malformed leaves the last good setting in place.
module uart_rx_config_set #(
  parameter int         busWIDTH  = 24,
  parameter int         CLK_DIV   = 87,
  parameter logic [7:0] HDR_BYTE  = 8'hA5,
  parameter int         TOUT_BITS = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uRx,
  input  logic [busWIDTH-1:0] busDefault,
  output logic [busWIDTH-1:0] busNow,
  output logic                busUpdate,
  output logic [7:0]          rxByte,
  output logic                rxValid,
  output logic                frameErr,
  output logic                csumErr
);

  localparam int BUS_BYTES = busWIDTH / 8;
  localparam int BAUD_W    = $clog2(CLK_DIV);
  localparam int TOUT_CYC  = TOUT_BITS * CLK_DIV;
  localparam int TOUT_W    = $clog2(TOUT_CYC);
  localparam int IDX_W     = $clog2(BUS_BYTES + 1);

  localparam logic [BAUD_W-1:0] HALF_M1  = BAUD_W'(CLK_DIV / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_M1  = BAUD_W'(CLK_DIV - 1);
  localparam logic [TOUT_W-1:0] TOUT_M1  = TOUT_W'(TOUT_CYC - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BUS_BYTES - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    F_HUNT = 2'd0,
    F_DATA = 2'd1,
    F_CSUM = 2'd2
  } frame_state_t;

  // ---------------- input synchroniser ----------------
  logic rx_meta_r, rx_sync_r, rx_prev_r;
  logic fall_s;

  // Two-stage synchroniser plus one delayed copy for edge detection; idle-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uRx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  assign fall_s = rx_prev_r & ~rx_sync_r;

  // ---------------- byte receiver ----------------
  rx_state_t         rx_state_r, rx_next_s;
  logic [BAUD_W-1:0] baud_cnt_r;
  logic [3:0]        bit_cnt_r;
  logic [7:0]        shift_r;
  logic              baud_hit_s;
  logic              baud_clr_s;
  logic              sample_bit_s;
  logic              stop_good_s;
  logic              stop_bad_s;

  assign baud_hit_s = (baud_cnt_r == FULL_M1);

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_r <= RX_IDLE;
    end else begin
      rx_state_r <= rx_next_s;
    end
  end

  // Receiver next-state: start-bit qualification at half bit, then full-bit sampling.
  always_comb begin
    rx_next_s = rx_state_r;
    case (rx_state_r)
      RX_IDLE: begin
        if (fall_s) rx_next_s = RX_START;
        else        rx_next_s = RX_IDLE;
      end
      RX_START: begin
        if (baud_cnt_r == HALF_M1) begin
          if (rx_sync_r) rx_next_s = RX_IDLE;
          else           rx_next_s = RX_DATA;
        end else begin
          rx_next_s = RX_START;
        end
      end
      RX_DATA: begin
        if (baud_hit_s && (bit_cnt_r == 4'd7)) rx_next_s = RX_STOP;
        else                                    rx_next_s = RX_DATA;
      end
      RX_STOP: begin
        if (baud_hit_s) rx_next_s = RX_IDLE;
        else            rx_next_s = RX_STOP;
      end
      default: rx_next_s = RX_IDLE;
    endcase
  end

  // Receiver strobes: when to restart the baud counter, shift a bit, or judge the stop bit.
  always_comb begin
    baud_clr_s   = 1'b0;
    sample_bit_s = 1'b0;
    stop_good_s  = 1'b0;
    stop_bad_s   = 1'b0;
    case (rx_state_r)
      RX_IDLE: begin
        baud_clr_s = 1'b1;
      end
      RX_START: begin
        if (baud_cnt_r == HALF_M1) baud_clr_s = 1'b1;
        else                       baud_clr_s = 1'b0;
      end
      RX_DATA: begin
        baud_clr_s   = baud_hit_s;
        sample_bit_s = baud_hit_s;
      end
      RX_STOP: begin
        baud_clr_s  = baud_hit_s;
        stop_good_s = baud_hit_s & rx_sync_r;
        stop_bad_s  = baud_hit_s & ~rx_sync_r;
      end
      default: begin
        baud_clr_s = 1'b1;
      end
    endcase
  end

  // Receiver datapath: baud/bit counters, LSB-first shifter and registered byte outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_r <= '0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      rxByte     <= 8'h00;
      rxValid    <= 1'b0;
      frameErr   <= 1'b0;
    end else begin
      if (baud_clr_s) baud_cnt_r <= '0;
      else            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);

      if (rx_state_r == RX_IDLE) bit_cnt_r <= 4'd0;
      else if (sample_bit_s)     bit_cnt_r <= bit_cnt_r + 4'd1;

      if (sample_bit_s) shift_r <= {rx_sync_r, shift_r[7:1]};

      if (stop_good_s) rxByte <= shift_r;
      rxValid  <= stop_good_s;
      frameErr <= stop_bad_s;
    end
  end

  // ---------------- frame parser ----------------
  frame_state_t        frame_state_r, frame_next_s;
  logic [busWIDTH-1:0] shadow_r;
  logic [7:0]          xor_r;
  logic [IDX_W-1:0]    idx_r;
  logic [TOUT_W-1:0]   tout_cnt_r;
  logic                tout_hit_s;
  logic                start_s;
  logic                store_s;
  logic                load_s;
  logic                bad_s;

  assign tout_hit_s = (frame_state_r != F_HUNT) && (tout_cnt_r == TOUT_M1);

  // Parser state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_state_r <= F_HUNT;
    end else begin
      frame_state_r <= frame_next_s;
    end
  end

  // Parser next-state: any framing error or inter-byte timeout drops back to hunting.
  always_comb begin
    frame_next_s = frame_state_r;
    case (frame_state_r)
      F_HUNT: begin
        if (rxValid && (rxByte == HDR_BYTE)) frame_next_s = F_DATA;
        else                                 frame_next_s = F_HUNT;
      end
      F_DATA: begin
        if (frameErr || tout_hit_s)           frame_next_s = F_HUNT;
        else if (rxValid && (idx_r == LAST_IDX)) frame_next_s = F_CSUM;
        else                                   frame_next_s = F_DATA;
      end
      F_CSUM: begin
        if (frameErr || tout_hit_s || rxValid) frame_next_s = F_HUNT;
        else                                   frame_next_s = F_CSUM;
      end
      default: frame_next_s = F_HUNT;
    endcase
  end

  // Parser strobes: header accept, payload store, checksum accept or reject.
  always_comb begin
    start_s = 1'b0;
    store_s = 1'b0;
    load_s  = 1'b0;
    bad_s   = 1'b0;
    case (frame_state_r)
      F_HUNT: begin
        start_s = rxValid && (rxByte == HDR_BYTE);
      end
      F_DATA: begin
        store_s = rxValid;
      end
      F_CSUM: begin
        load_s = rxValid && (rxByte == xor_r);
        bad_s  = rxValid && (rxByte != xor_r);
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
  end

  // Parser datapath: payload shadow, running XOR, byte index, timeout and bus commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      busNow     <= busDefault;
      busUpdate  <= 1'b0;
      csumErr    <= 1'b0;
      shadow_r   <= '0;
      xor_r      <= 8'h00;
      idx_r      <= '0;
      tout_cnt_r <= '0;
    end else begin
      busUpdate <= load_s;
      csumErr   <= bad_s;
      if (load_s) busNow <= shadow_r;

      if (start_s) begin
        idx_r <= '0;
        xor_r <= 8'h00;
      end else if (store_s) begin
        for (int b = 0; b < BUS_BYTES; b++) begin
          if (idx_r == IDX_W'(b)) shadow_r[busWIDTH-1-8*b -: 8] <= rxByte;
        end
        xor_r <= xor_r ^ rxByte;
        idx_r <= idx_r + IDX_W'(1);
      end

      if ((frame_state_r == F_HUNT) || rxValid) tout_cnt_r <= '0;
      else                                      tout_cnt_r <= tout_cnt_r + TOUT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_config_set.sv
// Directed bench for uart_rx_config_set: bit-level UART driver, pulse
// counters sampled on the falling clock edge, hand-computed frame results.
module tb_uart_rx_config_set;

  localparam int CLK_DIV = 87;

  logic        clk = 1'b0;
  logic        rst;
  logic        uRx;
  logic [23:0] busDefault;
  logic [23:0] busNow;
  logic        busUpdate;
  logic [7:0]  rxByte;
  logic        rxValid;
  logic        frameErr;
  logic        csumErr;

  uart_rx_config_set #(
    .busWIDTH  (24),
    .CLK_DIV   (CLK_DIV),
    .HDR_BYTE  (8'hA5),
    .TOUT_BITS (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uRx        (uRx),
    .busDefault (busDefault),
    .busNow     (busNow),
    .busUpdate  (busUpdate),
    .rxByte     (rxByte),
    .rxValid    (rxValid),
    .frameErr   (frameErr),
    .csumErr    (csumErr)
  );

  always #50 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // pulse monitor
  int          n_valid = 0, n_ferr = 0, n_cerr = 0, n_upd = 0;
  int          n_overlap = 0, n_stray = 0;
  int          cyc = 0, last_valid_cyc = 0, last_upd_cyc = 0;
  logic [23:0] prev_bus = 24'h000000;
  int          s_valid, s_ferr, s_cerr, s_upd;

  // Count output pulses once per cycle, away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rxValid)   begin n_valid <= n_valid + 1; last_valid_cyc <= cyc; end
    if (frameErr)  n_ferr <= n_ferr + 1;
    if (csumErr)   n_cerr <= n_cerr + 1;
    if (busUpdate) begin n_upd <= n_upd + 1; last_upd_cyc <= cyc; end
    if ((rxValid && frameErr) || (busUpdate && csumErr)) n_overlap <= n_overlap + 1;
    if (!rst && (busNow !== prev_bus) && !busUpdate) n_stray <= n_stray + 1;
    prev_bus <= busNow;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_valid = n_valid;
    s_ferr  = n_ferr;
    s_cerr  = n_cerr;
    s_upd   = n_upd;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_lvl);
    uRx = 1'b0;
    wait_clks(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      uRx = b[i];
      wait_clks(CLK_DIV);
    end
    uRx = stop_lvl;
    wait_clks(CLK_DIV);
    uRx = 1'b1;
    if (!stop_lvl) wait_clks(CLK_DIV);
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] cs);
    send_byte(h, 1'b1);
    send_byte(d0, 1'b1);
    send_byte(d1, 1'b1);
    send_byte(d2, 1'b1);
    send_byte(cs, 1'b1);
    wait_clks(2 * CLK_DIV);
  endtask

  initial begin
    rst        = 1'b1;
    uRx        = 1'b1;
    busDefault = 24'h010A00;
    wait_clks(5);
    rst = 1'b0;
    wait_clks(200);

    // 1: reset state, quiet line
    check("reset_bus",    32'(busNow), 32'h00010A00);
    check("reset_byte",   32'(rxByte), 32'h00);
    check("idle_pulses",  32'(n_valid + n_ferr + n_cerr + n_upd), 32'd0);

    // 2: good frame, payload 01 14 00, checksum 01^14^00 = 15
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h14, 1'b1);
    send_byte(8'h00, 1'b1);
    check("midframe_bus", 32'(busNow), 32'h00010A00);
    send_byte(8'h15, 1'b1);
    wait_clks(2 * CLK_DIV);
    check("good_bus",     32'(busNow), 32'h00011400);
    check("good_valid",   32'(n_valid - s_valid), 32'd5);
    check("good_upd",     32'(n_upd - s_upd), 32'd1);
    check("good_byte",    32'(rxByte), 32'h15);
    check("upd_latency",  32'(last_upd_cyc - last_valid_cyc), 32'd1);

    // 3: checksum 02^20^30 = 12, send 13
    snap();
    send_frame(8'hA5, 8'h02, 8'h20, 8'h30, 8'h13);
    check("csum_err",     32'(n_cerr - s_cerr), 32'd1);
    check("csum_upd",     32'(n_upd - s_upd), 32'd0);
    check("csum_bus",     32'(busNow), 32'h00011400);

    // 4: 0x55 with a zero stop bit, then a good frame (00^32^10 = 22)
    snap();
    send_byte(8'h55, 1'b0);
    wait_clks(2 * CLK_DIV);
    check("ferr_pulse",   32'(n_ferr - s_ferr), 32'd1);
    check("ferr_valid",   32'(n_valid - s_valid), 32'd0);
    check("ferr_byte",    32'(rxByte), 32'h13);
    snap();
    send_frame(8'hA5, 8'h00, 8'h32, 8'h10, 8'h22);
    check("after_ferr",   32'(busNow), 32'h00003210);
    check("after_ferr_u", 32'(n_upd - s_upd), 32'd1);

    // 5: header, one byte, 25 idle bit-times, then the rest -> aborted
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    wait_clks(25 * CLK_DIV);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h06, 1'b1);
    wait_clks(2 * CLK_DIV);
    check("tout_valid",   32'(n_valid - s_valid), 32'd6);
    check("tout_upd",     32'(n_upd - s_upd), 32'd0);
    check("tout_cerr",    32'(n_cerr - s_cerr), 32'd0);
    check("tout_bus",     32'(busNow), 32'h00003210);
    send_frame(8'hA5, 8'h01, 8'h64, 8'hFF, 8'h9A);
    check("after_tout",   32'(busNow), 32'h000164FF);
    // header value inside payload is data: A5^00^A5 = 00
    send_frame(8'hA5, 8'hA5, 8'h00, 8'hA5, 8'h00);
    check("hdr_in_data",  32'(busNow), 32'h00A500A5);

    // 6: a low pulse shorter than half a bit is rejected at the start-bit check
    snap();
    uRx = 1'b0;
    wait_clks(30);
    uRx = 1'b1;
    wait_clks(12 * CLK_DIV);
    check("glitch_valid", 32'(n_valid - s_valid), 32'd0);
    check("glitch_ferr",  32'(n_ferr - s_ferr), 32'd0);

    // reset in the middle of a frame and of a byte
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    busDefault = 24'h123456;
    uRx = 1'b0;
    wait_clks(300);
    rst = 1'b1;
    uRx = 1'b1;
    wait_clks(5);
    check("rst_bus",      32'(busNow), 32'h00123456);
    rst = 1'b0;
    wait_clks(2 * CLK_DIV);
    check("rst_byte",     32'(rxByte), 32'h00);
    send_byte(8'h14, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h15, 1'b1);
    wait_clks(2 * CLK_DIV);
    check("rst_hunt_upd", 32'(n_upd - s_upd), 32'd0);
    check("rst_hunt_bus", 32'(busNow), 32'h00123456);
    check("rst_valid",    32'(n_valid - s_valid), 32'd5);
    send_frame(8'hA5, 8'h0A, 8'h0B, 8'h0C, 8'h0D);
    check("after_rst",    32'(busNow), 32'h000A0B0C);

    check("exclusive",    32'(n_overlap), 32'd0);
    check("stray_change", 32'(n_stray), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
